// File: rtl/intr_moderator.sv
`default_nettype none
// intr_moderator: read-to-clear cause register, mask register and interval throttle
// driving a level interrupt request. Rev 1.0

module intr_moderator #(
  parameter int NUM_CAUSES = 16,
  parameter int TICK_DIV   = 256,
  parameter int CNT_BITS   = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NUM_CAUSES-1:0] cause_pulse,
  input  logic                  ics_wr,
  input  logic [NUM_CAUSES-1:0] ics_data,
  input  logic                  icr_rd,
  output logic [NUM_CAUSES-1:0] icr_value,
  input  logic                  ims_wr,
  input  logic [NUM_CAUSES-1:0] ims_data,
  input  logic                  imc_wr,
  input  logic [NUM_CAUSES-1:0] imc_data,
  output logic [NUM_CAUSES-1:0] ims_value,
  input  logic [CNT_BITS-1:0]   itr_interval,
  output logic                  intr_request
);

  localparam int              PRE_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] C_PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ASSERTED = 2'd1,
    S_HOLDOFF  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [NUM_CAUSES-1:0] r_icr;
  logic [NUM_CAUSES-1:0] r_ims;
  logic [CNT_BITS-1:0]   r_cnt;
  logic [PRE_W-1:0]      r_pre;
  logic                  r_intr;
  logic                  w_pending;
  logic                  w_load;
  logic                  w_wrap;

  assign w_pending    = |(r_icr & r_ims);
  assign w_wrap       = (r_pre == C_PRE_MAX);
  assign icr_value    = r_icr;
  assign ims_value    = r_ims;
  assign intr_request = r_intr;

  // Set wins over read-clear so an event coinciding with the host read is not lost.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_icr <= '0;
      r_ims <= '0;
    end else begin
      r_icr <= (icr_rd ? '0 : r_icr) | cause_pulse | (ics_wr ? ics_data : '0);
      r_ims <= (r_ims | (ims_wr ? ims_data : '0)) & ~(imc_wr ? imc_data : '0);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pending) begin
          w_next_state = S_ASSERTED;
          w_load       = 1'b1;
        end
      end
      S_ASSERTED: begin
        if (!w_pending) begin
          w_next_state = (r_cnt == '0) ? S_IDLE : S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (r_cnt == '0) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_intr  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_intr  <= (w_next_state == S_ASSERTED);
    end
  end

  // Interval is captured only on window entry; the counter saturates at zero.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= '0;
      r_pre <= '0;
    end else if (w_load) begin
      r_cnt <= itr_interval;
      r_pre <= '0;
    end else if (r_state != S_IDLE) begin
      r_pre <= w_wrap ? '0 : r_pre + 1'b1;
      if (w_wrap && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_intr_moderator.sv
`default_nettype none
// tb_intr_moderator: directed scoreboard bench for intr_moderator (TICK_DIV=4).

module tb_intr_moderator;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [15:0] cause_pulse;
  logic        ics_wr;
  logic [15:0] ics_data;
  logic        icr_rd;
  logic [15:0] icr_value;
  logic        ims_wr;
  logic [15:0] ims_data;
  logic        imc_wr;
  logic [15:0] imc_data;
  logic [15:0] ims_value;
  logic [15:0] itr_interval;
  logic        intr_request;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];

  intr_moderator #(
    .NUM_CAUSES(16),
    .TICK_DIV  (4),
    .CNT_BITS  (16)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .cause_pulse (cause_pulse),
    .ics_wr      (ics_wr),
    .ics_data    (ics_data),
    .icr_rd      (icr_rd),
    .icr_value   (icr_value),
    .ims_wr      (ims_wr),
    .ims_data    (ims_data),
    .imc_wr      (imc_wr),
    .imc_data    (imc_data),
    .ims_value   (ims_value),
    .itr_interval(itr_interval),
    .intr_request(intr_request)
  );

  always #5 aclk = ~aclk;

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%0h expected=<queued value>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn      = 1'b0;
    cause_pulse  = '0;
    ics_wr       = 1'b0;
    ics_data     = '0;
    icr_rd       = 1'b0;
    ims_wr       = 1'b0;
    ims_data     = '0;
    imc_wr       = 1'b0;
    imc_data     = '0;
    itr_interval = '0;
    repeat (3) cyc();
    aresetn = 1'b1;
    cyc();

    push("rst_icr", 32'h0);  chk({16'h0, icr_value});
    push("rst_ims", 32'h0);  chk({16'h0, ims_value});
    push("rst_intr", 32'h0); chk({31'h0, intr_request});

    // Cause with mask closed, then open the mask
    cause_pulse = 16'h0008; cyc(); cause_pulse = '0;
    push("t1_icr", 32'h8);   chk({16'h0, icr_value});
    push("t1_intr_masked", 32'h0); chk({31'h0, intr_request});
    ims_wr = 1'b1; ims_data = 16'h0008; cyc(); ims_wr = 1'b0; ims_data = '0;
    push("t1_ims", 32'h8);   chk({16'h0, ims_value});
    push("t1_intr_c1", 32'h0); chk({31'h0, intr_request});
    cyc();
    push("t1_intr_c2", 32'h1); chk({31'h0, intr_request});
    icr_rd = 1'b1; cyc(); icr_rd = 1'b0;
    push("t1_intr_rd1", 32'h1); chk({31'h0, intr_request});
    cyc();
    push("t1_intr_fall", 32'h0); chk({31'h0, intr_request});

    // Read-clear coinciding with new cause, I=0
    ims_wr = 1'b1; ims_data = 16'hFFFF; cyc(); ims_wr = 1'b0; ims_data = '0;
    ics_wr = 1'b1; ics_data = 16'h0001; cyc(); ics_wr = 1'b0; ics_data = '0;
    cyc();
    push("t2_intr_up", 32'h1); chk({31'h0, intr_request});
    icr_rd = 1'b1; cause_pulse = 16'h0020; cyc(); icr_rd = 1'b0; cause_pulse = '0;
    push("t2_icr", 32'h20);  chk({16'h0, icr_value});
    for (int k = 0; k < 3; k++) begin
      push("t2_intr_hold", 32'h1); chk({31'h0, intr_request});
      cyc();
    end
    icr_rd = 1'b1; cyc(); icr_rd = 1'b0; cyc(); cyc();
    push("t2_intr_clear", 32'h0); chk({31'h0, intr_request});

    // Throttle: TICK_DIV=4, I=3, next rise at T+14
    itr_interval = 16'd3;
    cause_pulse = 16'h0001; cyc(); cause_pulse = '0; cyc();
    push("t3_rise_T", 32'h1); chk({31'h0, intr_request});
    cyc();
    icr_rd = 1'b1;
    push("t3_T1", 32'h1); chk({31'h0, intr_request});
    cyc(); icr_rd = 1'b0; cause_pulse = 16'h0002;
    push("t3_T2", 32'h1); chk({31'h0, intr_request});
    cyc(); cause_pulse = '0;
    for (int k = 3; k <= 14; k++) begin
      if (k == 5) itr_interval = 16'd0;
      push($sformatf("t3_T%0d", k), (k == 14) ? 32'h1 : 32'h0);
      chk({31'h0, intr_request});
      if (k == 4) begin
        push("t3_icr_held", 32'h2); chk({16'h0, icr_value});
      end
      if (k < 14) cyc();
    end
    icr_rd = 1'b1; cyc(); icr_rd = 1'b0; cyc();
    push("t3_clear", 32'h0); chk({31'h0, intr_request});

    // Mask set and clear same bit: clear wins
    ims_wr = 1'b1; imc_wr = 1'b1; ims_data = 16'h0004; imc_data = 16'h0004;
    cyc();
    ims_wr = 1'b0; imc_wr = 1'b0; ims_data = '0; imc_data = '0;
    push("t4_ims", 32'hFFFB); chk({16'h0, ims_value});

    // I=0: one-cycle low gap
    cause_pulse = 16'h0001; cyc(); cause_pulse = '0; cyc();
    push("t6_rise", 32'h1); chk({31'h0, intr_request});
    cyc(); icr_rd = 1'b1;
    cyc(); icr_rd = 1'b0; cause_pulse = 16'h0001;
    cyc(); cause_pulse = '0;
    push("t6_low", 32'h0); chk({31'h0, intr_request});
    cyc();
    push("t6_high", 32'h1); chk({31'h0, intr_request});
    icr_rd = 1'b1; cyc(); icr_rd = 1'b0; cyc(); cyc();

    // Async reset mid-HOLDOFF with ICR=0x0003
    itr_interval = 16'd3;
    cause_pulse = 16'h0001; cyc(); cause_pulse = '0; cyc();
    push("t5_rise", 32'h1); chk({31'h0, intr_request});
    cyc(); icr_rd = 1'b1;
    cyc(); icr_rd = 1'b0; cause_pulse = 16'h0003;
    cyc(); cause_pulse = '0; cyc();
    push("t5_hold_intr", 32'h0); chk({31'h0, intr_request});
    push("t5_hold_icr", 32'h3);  chk({16'h0, icr_value});
    #2 aresetn = 1'b0;
    #1;
    push("t5_rst_icr", 32'h0);  chk({16'h0, icr_value});
    push("t5_rst_ims", 32'h0);  chk({16'h0, ims_value});
    push("t5_rst_intr", 32'h0); chk({31'h0, intr_request});
    cyc(); #2 aresetn = 1'b1;
    cyc();
    cause_pulse = 16'h0001; cyc(); cause_pulse = '0;
    cyc(); cyc();
    push("t5_post_icr", 32'h1);  chk({16'h0, icr_value});
    push("t5_post_intr", 32'h0); chk({31'h0, intr_request});
    ims_wr = 1'b1; ims_data = 16'h0001; cyc(); ims_wr = 1'b0; ims_data = '0;
    cyc();
    push("t5_post_rise", 32'h1); chk({31'h0, intr_request});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
